// File: rtl/video_pkg.sv
// Shared video timing constants and pattern encodings.
// Used by the pattern source and by downstream video filters.
package video_pkg;

  localparam int VID_H_ACTIVE = 1600;
  localparam int VID_H_FP     = 24;
  localparam int VID_H_SYNC   = 80;
  localparam int VID_H_BP     = 96;
  localparam int VID_V_ACTIVE = 900;
  localparam int VID_V_FP     = 1;
  localparam int VID_V_SYNC   = 3;
  localparam int VID_V_BP     = 96;
  localparam int VID_SOLID_Y  = 128;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_BARS  = 2'd3
  } pat_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Bar luma is idx*32, saturating once idx passes the eighth bar.
  function automatic logic [7:0] bar_luma(input logic [3:0] idx);
    bar_luma = (idx > 4'd7) ? 8'hff : {idx[2:0], 5'b0};
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Raster position counters for the pattern source.
// Holds while adv is low; wraps at the end of each line/frame.
module video_timing_cnt #(
  parameter int H_TOTAL = 1800,
  parameter int V_TOTAL = 1000,
  parameter int HW      = 11,
  parameter int VW      = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          h_wrap,
  output logic          frame_end
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  assign h_wrap    = (h_cnt == H_LAST);
  assign frame_end = h_wrap && (v_cnt == V_LAST);

  // Advance the raster position one pixel per enabled clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (adv) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source with raster timing and sync.
// Run/drain control keeps frames whole when the enable drops.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = VID_H_ACTIVE,
  parameter int H_FP     = VID_H_FP,
  parameter int H_SYNC   = VID_H_SYNC,
  parameter int H_BP     = VID_H_BP,
  parameter int V_ACTIVE = VID_V_ACTIVE,
  parameter int V_FP     = VID_V_FP,
  parameter int V_SYNC   = VID_V_SYNC,
  parameter int V_BP     = VID_V_BP,
  parameter int SOLID_Y  = VID_SOLID_Y
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] pat_sel_i,
  output logic [7:0] y_o,
  output logic       dv_o,
  output logic       hs_o,
  output logic       vs_o,
  output logic       busy_o,
  output logic [7:0] frame_cnt_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] BAR_LAST = 16'(H_ACTIVE / 8 - 1);

  logic [1:0]    rst_q;
  logic          rst_n;
  state_e        state;
  logic          active;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap;
  logic          frame_end;
  logic [15:0]   h_ext;
  logic [15:0]   v_ext;
  logic          first_px;
  pat_e          pat_q;
  pat_e          pat_now;
  logic [15:0]   bar_px;
  logic [3:0]    bar_idx;
  logic          dv_n;
  logic          hs_n;
  logic          vs_n;
  logic [7:0]    y_pat;
  logic [7:0]    y_n;

  // Assert reset at once, release it two clocks later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_q <= '0;
    else      rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_n  = rst_q[1];
  assign active = (state != IDLE);

  video_timing_cnt #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .HW      (HW),
    .VW      (VW)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv       (active),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .h_wrap    (h_wrap),
    .frame_end (frame_end)
  );

  assign h_ext    = 16'(h_cnt);
  assign v_ext    = 16'(v_cnt);
  assign first_px = (h_cnt == '0) && (v_cnt == '0);

  // Run control, busy flag and completed-frame count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy_o      <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      if (active && frame_end) frame_cnt_o <= frame_cnt_o + 8'd1;
      unique case (state)
        IDLE: begin
          if (en_i) begin
            state  <= RUN;
            busy_o <= 1'b1;
          end
        end
        RUN: begin
          if (!en_i) begin
            state  <= frame_end ? IDLE : DRAIN;
            busy_o <= !frame_end;
          end
        end
        DRAIN: begin
          if (en_i) begin
            state <= RUN;
          end else if (frame_end) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Latch the pattern select only at the top-left pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                pat_q <= PAT_SOLID;
    else if (active && first_px) pat_q <= pat_e'(pat_sel_i);
  end

  // Bar index: steps every eighth of the active line, cleared per line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (!active || h_wrap) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (h_ext < H_ACT) begin
      if (bar_px == BAR_LAST) begin
        bar_px  <= '0;
        bar_idx <= (bar_idx == 4'hf) ? bar_idx : bar_idx + 4'd1;
      end else begin
        bar_px <= bar_px + 16'd1;
      end
    end
  end

  // Pixel and sync values for the current raster position.
  always_comb begin
    pat_now = first_px ? pat_e'(pat_sel_i) : pat_q;
    dv_n    = active && (h_ext < H_ACT) && (v_ext < V_ACT);
    hs_n    = active && (h_ext >= HS_BEG) && (h_ext < HS_END);
    vs_n    = active && (v_ext >= VS_BEG) && (v_ext < VS_END);
    y_pat   = '0;
    unique case (pat_now)
      PAT_SOLID: y_pat = 8'(SOLID_Y);
      PAT_RAMP:  y_pat = h_ext[10:3] + frame_cnt_o;
      PAT_CHECK: y_pat = (h_ext[5] ^ v_ext[5]) ? 8'hff : 8'h00;
      PAT_BARS:  y_pat = bar_luma(bar_idx);
      default:   y_pat = '0;
    endcase
    y_n = dv_n ? y_pat : 8'h00;
  end

  // Register the video outputs together, one clock behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_o  <= '0;
      dv_o <= 1'b0;
      hs_o <= 1'b0;
      vs_o <= 1'b0;
    end else begin
      y_o  <= y_n;
      dv_o <= dv_n;
      hs_o <= hs_n;
      vs_o <= vs_n;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a 24x7 raster.
// Expected pixels come from raster position, mode and frame count.
module tb_video_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] pat_sel;
  logic [7:0] y_o;
  logic       dv_o;
  logic       hs_o;
  logic       vs_o;
  logic       busy_o;
  logic [7:0] frame_cnt_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE (16),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (3),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .SOLID_Y  (128)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .pat_sel_i   (pat_sel),
    .y_o         (y_o),
    .dv_o        (dv_o),
    .hs_o        (hs_o),
    .vs_o        (vs_o),
    .busy_o      (busy_o),
    .frame_cnt_o (frame_cnt_o)
  );

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_y(input int mode, input int h,
                               input int v, input int fc);
    int idx;
    if (!(h < 16 && v < 4)) return 0;
    case (mode)
      0: return 128;
      1: return ((h >> 3) + fc) % 256;
      2: return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 255 : 0;
      default: begin
        idx = h / 2;
        return (idx > 7) ? 255 : idx * 32;
      end
    endcase
  endfunction

  task automatic chk_quiet(input string tag, input int fc);
    chk({tag, " y"}, 32'(y_o), 0);
    chk({tag, " dv"}, 32'(dv_o), 0);
    chk({tag, " hs"}, 32'(hs_o), 0);
    chk({tag, " vs"}, 32'(vs_o), 0);
    chk({tag, " busy"}, 32'(busy_o), 0);
    chk({tag, " fcnt"}, 32'(frame_cnt_o), 32'(fc));
  endtask

  task automatic run_frame(input string tag, input int mode, input int fc,
                           input int n_pos, input int chg_at,
                           input logic [1:0] new_pat,
                           input int drop_at, input int rise_at);
    int ndv = 0;
    int nhs = 0;
    int nvs = 0;
    int h, v, edv, ehs, evs, efc, ebusy;
    for (int k = 0; k < n_pos; k++) begin
      if (k == chg_at)  pat_sel = new_pat;
      if (k == drop_at) en = 1'b0;
      if (k == rise_at) en = 1'b1;
      step();
      h     = k % 24;
      v     = k / 24;
      edv   = (h < 16 && v < 4) ? 1 : 0;
      ehs   = (h >= 18 && h < 21) ? 1 : 0;
      evs   = (v == 5) ? 1 : 0;
      efc   = (k == 167) ? (fc + 1) % 256 : fc;
      ebusy = (k == 167 && !en) ? 0 : 1;
      chk($sformatf("%s dv k%0d", tag, k), 32'(dv_o), 32'(edv));
      chk($sformatf("%s hs k%0d", tag, k), 32'(hs_o), 32'(ehs));
      chk($sformatf("%s vs k%0d", tag, k), 32'(vs_o), 32'(evs));
      chk($sformatf("%s y k%0d", tag, k), 32'(y_o),
          32'(exp_y(mode, h, v, fc)));
      chk($sformatf("%s fcnt k%0d", tag, k), 32'(frame_cnt_o), 32'(efc));
      chk($sformatf("%s busy k%0d", tag, k), 32'(busy_o), 32'(ebusy));
      ndv += int'(dv_o);
      nhs += int'(hs_o);
      nvs += int'(vs_o);
    end
    if (n_pos == 168) begin
      chk({tag, " dv count"}, 32'(ndv), 64);
      chk({tag, " hs count"}, 32'(nhs), 21);
      chk({tag, " vs count"}, 32'(nvs), 24);
    end
  endtask

  initial begin
    int bad = 0;
    int edv;

    rst     = 1'b0;
    en      = 1'b0;
    pat_sel = 2'd0;
    step();
    step();
    chk_quiet("reset", 0);

    // Release with en already high: RUN no earlier than 2nd clock.
    en  = 1'b1;
    rst = 1'b1;
    step();
    chk("sync e1 busy", 32'(busy_o), 0);
    step();
    chk("sync e2 busy", 32'(busy_o), 0);
    step();
    chk("sync e3 busy", 32'(busy_o), 1);
    chk("sync e3 dv", 32'(dv_o), 0);

    // Solid frame, pattern changed mid-frame, then checkerboard.
    run_frame("s1", 0, 0, 168, 50, 2'd2, -1, -1);
    run_frame("s3", 2, 1, 168, -1, 2'd0, 30, -1);

    // Drained: idle and quiet, counters parked.
    for (int i = 0; i < 5; i++) chk_quiet($sformatf("idle%0d", i), 2);

    // Bars frame, aborted by reset mid-frame.
    pat_sel = 2'd3;
    en      = 1'b1;
    step();
    chk("s5 start busy", 32'(busy_o), 1);
    run_frame("s5", 3, 2, 56, -1, 2'd0, -1, -1);
    rst = 1'b0;
    #1;
    chk_quiet("abort", 0);
    pat_sel = 2'd1;
    @(negedge clk);
    step();
    rst = 1'b1;
    step();
    step();
    chk("s5 sync busy", 32'(busy_o), 0);
    step();
    chk("s5 restart busy", 32'(busy_o), 1);

    // Ramp frames from a fresh start; frame 3 toggles en.
    run_frame("r0", 1, 0, 168, -1, 2'd0, -1, -1);
    run_frame("r1", 1, 1, 168, -1, 2'd0, -1, -1);
    run_frame("r2", 1, 2, 168, -1, 2'd0, -1, -1);
    run_frame("r3", 1, 3, 168, -1, 2'd0, 30, 40);

    // Long run to the frame counter wrap, no gaps between frames.
    for (int f = 4; f < 256; f++) begin
      if (f == 255) chk("fcnt 255", 32'(frame_cnt_o), 255);
      for (int k = 0; k < 168; k++) begin
        step();
        edv = ((k % 24) < 16 && (k / 24) < 4) ? 1 : 0;
        if (dv_o !== edv[0]) bad++;
      end
    end
    chk("wrap dv cadence", 32'(bad), 0);
    chk("wrap fcnt", 32'(frame_cnt_o), 0);
    chk("wrap busy", 32'(busy_o), 1);

    // Final drain back to idle.
    en = 1'b0;
    repeat (168) step();
    chk("end busy", 32'(busy_o), 0);
    chk("end fcnt", 32'(frame_cnt_o), 1);
    chk("end dv", 32'(dv_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  H_ACTIVE, 1600, active pixels per line
  H_FP, 24, horizontal front porch, clocks
  H_SYNC, 80, hs pulse width, clocks
  H_BP, 96, horizontal back porch, clocks
  V_ACTIVE, 900, active lines per frame
  V_FP, 1, vertical front porch, lines
  V_SYNC, 3, vs pulse width, lines
  V_BP, 96, vertical back porch, lines
  SOLID_Y, 128, luma for the solid pattern
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all logic on rising edge
  rst  in  1  reset, asynchronous, active-low
  en_i  in  1  run request, level-sensitive
  pat_sel_i  in  2  pattern: 0 solid, 1 moving ramp, 2 checkerboard, 3 bars
  y_o  out  8  pixel luma
  dv_o  out  1  pixel valid, active-high
  hs_o  out  1  horizontal sync pulse, active-high
  vs_o  out  1  vertical sync pulse, active-high
  busy_o  out  1  high while a frame is in progress
  frame_cnt_o  out  8  completed-frame counter, wraps 255->0

Function
REQ-003 The block SHALL source the same y/dv/hs/vs stream that the filter consumes; every output SHALL be registered.
REQ-004 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-005 IDLE->RUN SHALL occur on the first clk with en_i=1; h_cnt and v_cnt SHALL be 0 on the first RUN cycle.
REQ-006 RUN->DRAIN SHALL occur when en_i=0; DRAIN SHALL finish the current frame; at the last counter position (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1), DRAIN->IDLE.
REQ-007 In RUN at the last counter position, the counters SHALL wrap to 0 and the next frame SHALL start with no gap.
REQ-008 H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL equivalently; h_cnt SHALL count 0..H_TOTAL-1; v_cnt SHALL increment when h_cnt wraps.
REQ-009 dv_o SHALL equal (h_cnt<H_ACTIVE and v_cnt<V_ACTIVE), delayed by 1 clk.
REQ-010 hs_o SHALL be high for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), on every line, delayed by 1 clk.
REQ-011 vs_o SHALL be high for entire lines with v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), delayed by 1 clk.
REQ-012 Output latency from counter state to y/dv/hs/vs SHALL be exactly 1 clk, aligned across all four.
REQ-013 y_o SHALL be 0 whenever dv_o=0.
REQ-014 Pattern 0: y = SOLID_Y.
REQ-015 Pattern 1: y = h_cnt[10:3] + frame_cnt, modulo 256.
REQ-016 Pattern 2: y = 255 if h_cnt[5] XOR v_cnt[5], else 0.
REQ-017 Pattern 3: y = bar_idx*32 (8-bit, saturating at 255), with bar_idx incremented every H_ACTIVE/8 active pixels and cleared at line start.
REQ-018 pat_sel_i SHALL be sampled only at h_cnt=0, v_cnt=0; a mid-frame change SHALL take effect at the next frame.
REQ-019 frame_cnt_o SHALL increment by 1 at each completed frame, in RUN or DRAIN.
REQ-020 busy_o SHALL be high in RUN and DRAIN, and low in IDLE.
REQ-021 en_i toggling 1->0->1 within one frame SHALL return DRAIN->RUN with no frame restart.
REQ-022 In IDLE, all video outputs SHALL be 0 and the counters SHALL hold at 0.

Reset
REQ-023 While rst=0, state SHALL be IDLE; y_o, dv_o, hs_o, vs_o, busy_o and frame_cnt_o SHALL be 0; the counters SHALL be 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, with no drain.
REQ-025 Reset deassertion SHALL be synchronized to clk; operation SHALL start no earlier than the 2nd clk after release.

Structure
REQ-026 The 1600x900 timing constants and the pattern encodings SHALL live in a shared video package, also used by fir_filter.
REQ-027 One sub-module, video_timing_cnt, SHALL hold h_cnt, v_cnt and the wrap/end-of-frame flags; pattern mux and FSM SHALL be in the top module.

Verification
REQ-028 The bench SHALL use H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (H_TOTAL=24, V_TOTAL=7) and cover these scenarios:
  Scenario 1: en_i=1, one frame -> 64 dv_o cycles; hs_o 3 clks wide starting at h_cnt=18, each line; vs_o high for all 24 clks of line 5; frame_cnt_o 0->1.
  Scenario 2: pat_sel=1, frame 0 -> pixel n of each line gives y=n>>3; frame 3, pixel 8 -> y=4.
  Scenario 3: pat_sel changed 0->2 mid-frame -> current frame stays SOLID_Y=128; next frame is the checkerboard.
  Scenario 4: en_i dropped at line 1 -> frame completes; busy_o falls after the last position; outputs 0; frame_cnt_o=1.
  Scenario 5: rst=0 at pixel 7 of line 2 -> all outputs 0 in the same cycle; en_i=1 after release -> a fresh frame from h=0, v=0.
  Scenario 6: en_i held for 256 frames -> frame_cnt_o wraps to 0; no gap between frames (dv_o period stays 24).
